bloom_table_ctrl: RTL
=====================

Name: bloom_table_ctrl

Overview:
- Owns the 1024-bit Bloom table register used by the censor path.
- Shares the table between two requesters:
  - the config side, which inserts words (sets two hash bits) or clears the table;
  - the lookup side, which queries a hash pair and receives a registered hit/miss.
- Arbitrates round-robin between the two sides and sequences a multi-cycle chunked clear.
- Exports the live table for debug/readback.

Parameters:
- TABLE_BITS, 1024, Bloom table size in bits; must be a multiple of CLR_W.
- HASH_W, 10, width of each hash index.
- CLR_W, 32, table bits zeroed per cycle during CLEAR.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config request accepted when valid&ready.
- cfg_op  in  1  0 = insert, 1 = clear.
- cfg_hash1  in  HASH_W  insert index 1.
- cfg_hash2  in  HASH_W  insert index 2.
- q_valid  in  1  query request valid.
- q_ready  out  1  query accepted when valid&ready.
- q_hash1  in  HASH_W  query index 1.
- q_hash2  in  HASH_W  query index 2.
- res_valid  out  1  query result valid.
- res_hit  out  1  table[q_hash1] & table[q_hash2].
- res_ready  in  1  result consumed when valid&ready.
- busy  out  1  high whenever state != IDLE.
- bloom_table  out  TABLE_BITS  current table contents.

Behaviour:
- Reset (clk edge with rst=1), regardless of state:
  - state=IDLE, table all zero (single cycle), clr_idx=0, prio_q=1;
  - res_valid=0, res_hit=0, busy=0.
  - Reset during CLEAR or RESULT aborts the operation; a pending result is dropped.
- Readiness:
  - q_ready = (state==IDLE) & (!cfg_valid | prio_q).
  - cfg_ready = (state==IDLE) & (!q_valid | !prio_q).
  - At most one request is accepted per cycle.
- Arbitration: after any accepted request, prio_q points to the other requester (prio_q=0 after a query, 1 after a config).
- Insert (cfg_op=0, accepted): table[cfg_hash1] and table[cfg_hash2] are set to 1 at the same edge. State stays IDLE. Equal hashes set one bit.
- Clear (cfg_op=1, accepted): go to CLEAR with clr_idx=0.
  - Each CLEAR cycle zeroes bits [clr_idx*CLR_W +: CLR_W], then increments clr_idx.
  - After chunk TABLE_BITS/CLR_W-1, return to IDLE with clr_idx=0.
  - Default configuration: 32 CLEAR cycles.
  - Both readies are low throughout.
- Query (accepted): at the accept edge, res_hit <= table[q_hash1] & table[q_hash2] and res_valid <= 1; state goes to RESULT.
  - Latency is 1 cycle.
  - The query sees all inserts accepted in earlier cycles.
- RESULT: res_valid and res_hit are held stable until res_valid&res_ready, then res_valid <= 0 and state returns to IDLE.
  - No new request is accepted in the cycle res_ready is sampled; the next accept is possible the following cycle.
- res_hit retains its last value after res_valid drops.
- Hash index >= TABLE_BITS: a query reads 0 for that bit; an insert ignores that bit.
- bloom_table reflects the register directly (no extra latency).

Test Plan:
1. Reset, then query (5,700) with res_ready=1 -> res_valid=1, res_hit=0 one cycle after accept; busy=1 for that cycle.
2. Insert (5,700), then query (5,700) -> res_hit=1. Then query (5,701) -> res_hit=0. bloom_table bits 5 and 700 are the only 1s.
3. Insert (5,700) and (31,32), then clear -> busy=1 with cfg_ready=q_ready=0 for exactly 32 cycles; afterwards bloom_table==0 and query (5,700) -> res_hit=0.
4. After reset, hold cfg_valid (insert 3,3) and q_valid (query 3,3) together -> query granted first (res_hit=0), then insert. A second query -> res_hit=1. Grants alternate while both requesters stay valid.
5. Query hit with res_ready=0 for 5 cycles -> res_valid=1 and res_hit=1 stable; q_ready=cfg_ready=0. Raise res_ready -> res_valid=0 next cycle, then q_ready=1.
6. Assert rst on the 10th CLEAR cycle, and separately during RESULT -> next cycle state=IDLE, table=0, res_valid=0, res_hit=0, busy=0, prio_q=1.

Source files
------------

// File: rtl/bloom_table_ctrl.sv
// ============================================================================
// Module   : bloom_table_ctrl
// Purpose  : Owns the Bloom table register; round-robin arbitrates inserts,
//            chunked clears and registered hit/miss queries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bloom_table_ctrl #(
    parameter int TABLE_BITS = 1024,
    parameter int HASH_W     = 10,
    parameter int CLR_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_op,
    input  logic [HASH_W-1:0]     cfg_hash1,
    input  logic [HASH_W-1:0]     cfg_hash2,
    input  logic                  q_valid,
    output logic                  q_ready,
    input  logic [HASH_W-1:0]     q_hash1,
    input  logic [HASH_W-1:0]     q_hash2,
    output logic                  res_valid,
    output logic                  res_hit,
    input  logic                  res_ready,
    output logic                  busy,
    output logic [TABLE_BITS-1:0] bloom_table
);

    localparam int c_num_chunks = TABLE_BITS / CLR_W;
    localparam int c_idx_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
    localparam logic [c_idx_w-1:0]    c_last_chunk = c_idx_w'(c_num_chunks - 1);
    localparam logic [TABLE_BITS-1:0] c_one        = TABLE_BITS'(1'b1);
    localparam logic [TABLE_BITS-1:0] c_chunk_ones = TABLE_BITS'({CLR_W{1'b1}});

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [TABLE_BITS-1:0]   r_table;
    logic [TABLE_BITS-1:0]   w_table_next;
    logic [c_idx_w-1:0]      r_clr_idx;
    logic                    r_prio_q;
    logic                    r_res_valid;
    logic                    r_res_hit;

    logic                    w_idle;
    logic                    w_q_acc;
    logic                    w_cfg_acc;
    logic                    w_q_hit;
    logic [31:0]             w_clr_base;
    logic [TABLE_BITS-1:0]   w_ins_mask;
    logic [TABLE_BITS-1:0]   w_q_mask1;
    logic [TABLE_BITS-1:0]   w_q_mask2;
    logic [TABLE_BITS-1:0]   w_clr_mask;

    assign w_idle    = (r_state == ST_IDLE);
    assign q_ready   = w_idle & (~cfg_valid | r_prio_q);
    assign cfg_ready = w_idle & (~q_valid | ~r_prio_q);
    assign w_q_acc   = q_valid & q_ready;
    assign w_cfg_acc = cfg_valid & cfg_ready & ~w_q_acc;

    // One-hot masks: a hash beyond the table shifts the 1 out, so out-of-range
    // indices read as 0 and are ignored on insert without any compare logic.
    assign w_ins_mask = (c_one << cfg_hash1) | (c_one << cfg_hash2);
    assign w_q_mask1  = c_one << q_hash1;
    assign w_q_mask2  = c_one << q_hash2;
    assign w_q_hit    = (|(r_table & w_q_mask1)) & (|(r_table & w_q_mask2));

    assign w_clr_base = 32'(r_clr_idx) * 32'(CLR_W);
    assign w_clr_mask = c_chunk_ones << w_clr_base;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_q_acc) begin
                    w_state_next = ST_RESULT;
                end else if (w_cfg_acc && cfg_op) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (r_clr_idx == c_last_chunk) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_table_next = r_table;
        if (r_state == ST_CLEAR) begin
            w_table_next = r_table & ~w_clr_mask;
        end else if (w_cfg_acc && !cfg_op) begin
            w_table_next = r_table | w_ins_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_table     <= '0;
            r_clr_idx   <= '0;
            r_prio_q    <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_table <= w_table_next;

            if (r_state == ST_CLEAR) begin
                r_clr_idx <= (r_clr_idx == c_last_chunk) ? '0 : r_clr_idx + c_idx_w'(1);
            end

            if (w_q_acc) begin
                r_prio_q <= 1'b0;
            end else if (w_cfg_acc) begin
                r_prio_q <= 1'b1;
            end

            // res_hit is only rewritten on a new query so it keeps its last value.
            if (w_q_acc) begin
                r_res_valid <= 1'b1;
                r_res_hit   <= w_q_hit;
            end else if ((r_state == ST_RESULT) && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign res_valid   = r_res_valid;
    assign res_hit     = r_res_hit;
    assign busy        = (r_state != ST_IDLE);
    assign bloom_table = r_table;

endmodule

`default_nettype wire
